// File: rtl/pipe_stage.sv
// pipe_stage: one-cycle valid/ready register slice with always-propagate sideband and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready; default is a single entry.
module pipe_stage #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       SIDE_W    = 1,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SIDE_W-1:0] out_side,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_out_data;
  logic [SIDE_W-1:0]   r_out_side;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic                w_acc;
  logic                w_drn;

  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_out_data;
  assign out_side  = r_out_side;
  assign stall_cnt = r_stall_cnt;
  assign w_acc     = in_valid && in_ready;
  assign w_drn     = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_acc) w_state_nxt = ONE;
        ONE: begin
`ifdef PIPE_STAGE_SKID_EN
          if (w_acc && !w_drn) w_state_nxt = TWO;
          else if (!w_acc && w_drn) w_state_nxt = EMPTY;
`else
          if (!w_acc && w_drn) w_state_nxt = EMPTY;
`endif
        end
        TWO:     if (w_drn) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] r_skid_data;
  logic              r_in_ready;

  // in_ready comes straight from a flop so out_ready never reaches it combinationally.
  assign in_ready = r_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_skid_data <= '0;
    end else begin
      r_in_ready <= (w_state_nxt != TWO);
      if (!flush && r_state == ONE && w_acc && !w_drn) r_skid_data <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data <= RESET_VAL;
    end else if (!flush) begin
      if (r_state == TWO) begin
        if (w_drn) r_out_data <= r_skid_data;
      end else if (w_acc && (r_state == EMPTY || w_drn)) begin
        r_out_data <= in_data;
      end
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_out_data <= RESET_VAL;
    else if (!flush && w_acc) r_out_data <= in_data;
  end
`endif

  // Sideband is a plain pipeline register, deliberately blind to handshake and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_out_side <= '0;
    else     r_out_side <= in_side;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage; expectations follow PIPE_STAGE_SKID_EN when it is defined.
module tb_pipe_stage;
  localparam int unsigned       DATA_W = 32;
  localparam int unsigned       SIDE_W = 2;
  localparam int unsigned       CNT_W  = 4;
  localparam logic [DATA_W-1:0] RV     = 32'hA5A5_0F0F;
  localparam logic [DATA_W-1:0] DA = 32'h1111_000A, DB = 32'h2222_000B;
  localparam logic [DATA_W-1:0] DC = 32'h3333_000C, DD = 32'h4444_000D;
  localparam logic [DATA_W-1:0] DE = 32'h5555_000E;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [SIDE_W-1:0] in_side = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [SIDE_W-1:0] out_side;
  logic              flush = 1'b0;
  logic [CNT_W-1:0]  stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  pipe_stage #(.DATA_W(DATA_W), .SIDE_W(SIDE_W), .CNT_W(CNT_W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_side(in_side), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_side(out_side),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_side = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_side = 2'b11;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_data !== RV) begin n_err++; $display("FAIL rst_data: got %h want %h", out_data, RV); end
    n_vec++; if (out_side !== 2'b00) begin n_err++; $display("FAIL rst_side: got %b want 00", out_side); end
    n_vec++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
    in_side = '0;
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = DATA_W'(k);
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b want 1", k, in_ready); end
      if (k == 1) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_pre_valid: got %b want 0", out_valid); end
      end
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_data !== DATA_W'(k))
        begin n_err++; $display("FAIL stream_beat[%0d]: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, k); end
    end
    in_valid = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    n_vec++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL stream_stall: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = DA;
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_data !== DA) begin n_err++; $display("FAIL bp_a: got v=%b d=%h want v=1 d=%h", out_valid, out_data, DA); end
    in_data = DB;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_drop: got %b want 0", in_ready); end
    in_data = DC;
`endif
    n_vec++; if (out_data !== DA) begin n_err++; $display("FAIL bp_hold1: got %h want %h", out_data, DA); end
    n_vec++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL bp_stall1: got %0d want 1", stall_cnt); end
    tick();
    tick();
    n_vec++; if (out_data !== DA || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold3: got d=%h rdy=%b want d=%h rdy=0", out_data, in_ready, DA); end
    n_vec++; if (stall_cnt !== 4'd3) begin n_err++; $display("FAIL bp_stall3: got %0d want 3", stall_cnt); end
    out_ready = 1'b1;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_reg: got %b want 0", in_ready); end
`else
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_comb: got %b want 1", in_ready); end
`endif
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_data !== DB) begin n_err++; $display("FAIL bp_b: got v=%b d=%h want v=1 d=%h", out_valid, out_data, DB); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    in_data = DC;
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_data !== DC) begin n_err++; $display("FAIL bp_c: got v=%b d=%h want v=1 d=%h", out_valid, out_data, DC); end
    in_valid = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    n_vec++; if (stall_cnt !== 4'd3) begin n_err++; $display("FAIL bp_stall_final: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = DA;
    tick();
    in_data = DB;
    tick();
    flush = 1'b1; in_data = DD; in_side = 2'b10;
    tick();
    flush = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== DA) begin n_err++; $display("FAIL flush_data_keep: got %h want %h", out_data, DA); end
    n_vec++; if (out_side !== 2'b10) begin n_err++; $display("FAIL flush_side: got %b want 10", out_side); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (out_valid !== 1'b0 || out_data === DD || out_data === DB)
        begin n_err++; $display("FAIL flush_no_leak[%0d]: got v=%b d=%h want v=0 d=%h", k, out_valid, out_data, DA); end
    end
    n_vec++; if (stall_cnt !== 4'd2) begin n_err++; $display("FAIL flush_stall: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_sideband();
    logic [SIDE_W-1:0] seq [4];
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b00; seq[3] = 2'b10;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = DA;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_side = seq[k];
      tick();
      n_vec++; if (out_side !== seq[k]) begin n_err++; $display("FAIL side[%0d]: got %b want %b", k, out_side, seq[k]); end
    end
    n_vec++; if (out_valid !== 1'b1 || out_data !== DA) begin n_err++; $display("FAIL side_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, DA); end
    in_side = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = DA;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_vec++; if (stall_cnt !== CNT_W'((k > 15) ? 15 : k))
        begin n_err++; $display("FAIL sat[%0d]: got %0d want %0d", k, stall_cnt, (k > 15) ? 15 : k); end
    end
    n_vec++; if (out_valid !== 1'b1 || out_data !== DA) begin n_err++; $display("FAIL sat_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, DA); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = DB; in_side = 2'b01;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_vec++; if (stall_cnt !== 4'd2 || out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre: got cnt=%0d v=%b want cnt=2 v=1", stall_cnt, out_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== RV) begin n_err++; $display("FAIL arst_data: got %h want %h", out_data, RV); end
    n_vec++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL arst_stall: got %0d want 0", stall_cnt); end
    n_vec++; if (in_ready !== 1'b1 || out_side !== 2'b00) begin n_err++; $display("FAIL arst_misc: got rdy=%b side=%b want rdy=1 side=00", in_ready, out_side); end
    tick();
    rst = 1'b0; in_valid = 1'b1; in_data = DE; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_data !== DE) begin n_err++; $display("FAIL arst_first: got v=%b d=%h want v=1 d=%h", out_valid, out_data, DE); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_no_old: got %b want 0", out_valid); end
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_sideband();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
